ysyx_23060236_tlb: RTL and testbench

//  Fully-associative translation cache beside ysyx_23060236_mmu: combinational lookup VPN->PPN, synchronous fill

---
 rtl/ysyx_23060236_mmu_pkg.sv | 12 +
 rtl/ysyx_23060236_tlb_penc.sv | 18 +
 rtl/ysyx_23060236_tlb.sv | 103 ++++++++++
 tb/tb_ysyx_23060236_tlb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_mmu_pkg.sv
// Shared MMU/TLB widths and the TLB entry layout.
// The MMU and TLB agree on VPN/PPN widths through this package.
package ysyx_23060236_mmu_pkg;
  localparam int VPN_W = 20;
  localparam int PPN_W = 20;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;
endpackage

// File: rtl/ysyx_23060236_tlb_penc.sv
// Lowest-set-bit priority encoder; picks the first free TLB slot for fills.
module ysyx_23060236_tlb_penc #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic [ENTRIES-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    any = |req;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/ysyx_23060236_tlb.sv
// Fully-associative VPN->PPN cache: combinational lookup, one-cycle fill,
// global flush, and hit/miss counters for the core.
module ysyx_23060236_tlb
  import ysyx_23060236_mmu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        lookup_valid,
  input  logic [19:0] tlb_araddr,
  output logic [19:0] tlb_rdata,
  output logic        tlb_hit,
  input  logic [19:0] tlb_awaddr,
  input  logic [19:0] tlb_wdata,
  input  logic        tlb_wvalid,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  tlb_entry_t [ENTRIES-1:0] ent_q, ent_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [31:0]              hit_cnt_q, hit_cnt_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;

  logic [ENTRIES-1:0] match;
  logic [ENTRIES-1:0] fill_match;
  logic [ENTRIES-1:0] invalid;
  logic [IDX_W-1:0]   inv_idx;
  logic               inv_any;
  logic [IDX_W-1:0]   fill_match_idx;
  logic [IDX_W-1:0]   fill_sel;
  logic               fill_hit;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign match[i]      = ent_q[i].valid & (ent_q[i].vpn == tlb_araddr);
    assign fill_match[i] = ent_q[i].valid & (ent_q[i].vpn == tlb_awaddr);
    assign invalid[i]    = ~ent_q[i].valid;
  end

  ysyx_23060236_tlb_penc #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_penc (
    .req(invalid),
    .idx(inv_idx),
    .any(inv_any)
  );

  // The fill policy keeps VPNs unique, so OR-muxing one-hot matches is exact.
  always_comb begin
    tlb_rdata      = '0;
    fill_match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      tlb_rdata      = tlb_rdata | (ent_q[i].ppn & {PPN_W{match[i]}});
      fill_match_idx = fill_match_idx | (fill_match[i] ? IDX_W'(i) : '0);
    end
  end

  assign tlb_hit  = |match;
  assign fill_hit = |fill_match;
  assign fill_sel = fill_hit ? fill_match_idx : (inv_any ? inv_idx : rr_ptr_q);

  always_comb begin
    ent_d      = ent_q;
    rr_ptr_d   = rr_ptr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent_d[i].valid = 1'b0;
      rr_ptr_d = '0;
    end else if (tlb_wvalid) begin
      ent_d[fill_sel].valid = 1'b1;
      ent_d[fill_sel].vpn   = tlb_awaddr;
      ent_d[fill_sel].ppn   = tlb_wdata;
      if (!fill_hit && !inv_any) rr_ptr_d = rr_ptr_q + IDX_W'(1);
    end

    if (lookup_valid) begin
      if (tlb_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else         miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q      <= '0;
      rr_ptr_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      ent_q      <= ent_d;
      rr_ptr_q   <= rr_ptr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_ysyx_23060236_tlb.sv
// Self-checking bench for the TLB: directed scenarios plus random traffic
// compared every cycle against a behavioural slot model.
module tb_ysyx_23060236_tlb;
  localparam int N = 8;

  logic        clock = 1'b0;
  logic        reset, flush, lookup_valid, tlb_wvalid, tlb_hit;
  logic [19:0] tlb_araddr, tlb_rdata, tlb_awaddr, tlb_wdata;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  ysyx_23060236_tlb #(.ENTRIES(N), .IDX_W(3)) dut (
    .clock(clock), .reset(reset), .flush(flush), .lookup_valid(lookup_valid),
    .tlb_araddr(tlb_araddr), .tlb_rdata(tlb_rdata), .tlb_hit(tlb_hit),
    .tlb_awaddr(tlb_awaddr), .tlb_wdata(tlb_wdata), .tlb_wvalid(tlb_wvalid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: slot table with replacement pointer and counters.
  bit          m_v[N];
  logic [19:0] m_vpn[N];
  logic [19:0] m_ppn[N];
  int          m_rr;
  logic [31:0] m_hits, m_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_lookup(input logic [19:0] va, output bit hit, output logic [19:0] pa);
    hit = 0;
    pa  = '0;
    foreach (m_v[i]) if (m_v[i] && m_vpn[i] == va) begin
      hit = 1;
      pa  = m_ppn[i];
    end
  endfunction

  always @(posedge clock) begin
    bit          h;
    logic [19:0] p;
    int          slot;
    if (reset) begin
      foreach (m_v[i]) m_v[i] = 0;
      m_rr = 0; m_hits = 0; m_misses = 0;
    end else begin
      m_lookup(tlb_araddr, h, p);
      if (lookup_valid) begin
        if (h) m_hits++;
        else   m_misses++;
      end
      if (flush) begin
        foreach (m_v[i]) m_v[i] = 0;
        m_rr = 0;
      end else if (tlb_wvalid) begin
        slot = -1;
        foreach (m_v[i]) if (slot < 0 && m_v[i] && m_vpn[i] == tlb_awaddr) slot = i;
        if (slot < 0) foreach (m_v[i]) if (slot < 0 && !m_v[i]) slot = i;
        if (slot < 0) begin
          slot = m_rr;
          m_rr = (m_rr + 1) % N;
        end
        m_v[slot] = 1; m_vpn[slot] = tlb_awaddr; m_ppn[slot] = tlb_wdata;
      end
    end
  end

  // Compare process: outputs vs model, mid-cycle.
  always @(negedge clock) begin
    bit          h;
    logic [19:0] p;
    if (chk_en) begin
      m_lookup(tlb_araddr, h, p);
      chk("model_hit", {31'b0, tlb_hit}, {31'b0, h});
      chk("model_rdata", {12'b0, tlb_rdata}, {12'b0, p});
      chk("model_hit_cnt", hit_cnt, m_hits);
      chk("model_miss_cnt", miss_cnt, m_misses);
      chk("match_onehot0", {31'b0, $onehot0(dut.match)}, 32'd1);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [19:0] va, input logic [19:0] pa);
    tlb_awaddr = va; tlb_wdata = pa; tlb_wvalid = 1;
    cyc();
    tlb_wvalid = 0;
  endtask

  task automatic look(input string name, input logic [19:0] va, input bit eh, input logic [19:0] ep);
    tlb_araddr = va;
    @(negedge clock);
    chk({name, "_hit"}, {31'b0, tlb_hit}, {31'b0, eh});
    if (eh) chk({name, "_rdata"}, {12'b0, tlb_rdata}, {12'b0, ep});
    cyc();
  endtask

  initial begin
    reset = 1; flush = 0; lookup_valid = 0; tlb_wvalid = 0;
    tlb_araddr = '0; tlb_awaddr = '0; tlb_wdata = '0;
    repeat (2) cyc();
    reset = 0;
    chk_en = 1;

    look("reset_lookup", 20'h12345, 0, 20'h0);
    chk("reset_rdata", {12'b0, tlb_rdata}, 32'h0);
    chk("reset_hit_cnt", hit_cnt, 32'd0);
    lookup_valid = 1;
    cyc();
    lookup_valid = 0;
    @(negedge clock);
    chk("miss_cnt_one", miss_cnt, 32'd1);
    cyc();

    // Read-during-write returns old contents.
    tlb_araddr = 20'h12345; tlb_awaddr = 20'h12345; tlb_wdata = 20'h0ABCD; tlb_wvalid = 1;
    @(negedge clock);
    chk("rdw_hit", {31'b0, tlb_hit}, 32'd0);
    cyc();
    tlb_wvalid = 0;
    look("after_fill", 20'h12345, 1, 20'h0ABCD);
    fill(20'h12345, 20'h00001);
    look("refresh", 20'h12345, 1, 20'h00001);

    // 12345 sits in slot 0; VPN 0..6 fill slots 1..7, then 7,8,9 evict slots 0,1,2.
    for (int v = 0; v < 10; v++) fill(20'(v), 20'(v + 20'h100));
    look("evict_12345", 20'h12345, 0, 20'h0);
    look("evict_vpn0", 20'h0, 0, 20'h0);
    look("evict_vpn1", 20'h1, 0, 20'h0);
    for (int v = 2; v < 10; v++) look("keep_vpn", 20'(v), 1, 20'(v + 20'h100));
    // Victim pointer at 3 now: next new VPN evicts slot 3 (VPN 2).
    fill(20'hAAAAA, 20'h55555);
    look("rr_evict_vpn2", 20'h2, 0, 20'h0);
    look("rr_keep_vpn3", 20'h3, 1, 20'h103);

    // Flush with simultaneous fill: fill dropped.
    tlb_awaddr = 20'hFFFFF; tlb_wdata = 20'h77777; tlb_wvalid = 1; flush = 1;
    cyc();
    tlb_wvalid = 0; flush = 0;
    look("flush_ffff", 20'hFFFFF, 0, 20'h0);
    look("flush_vpn5", 20'h5, 0, 20'h0);
    chk("flush_hit_cnt", hit_cnt, 32'd0);
    chk("flush_miss_cnt", miss_cnt, 32'd1);
    for (int v = 0; v < N + 1; v++) fill(20'(v + 20'h300), 20'(v));
    look("rr_zero_evict", 20'h300, 0, 20'h0);
    look("rr_zero_keep", 20'h301, 1, 20'h1);

    // Random traffic over a small VPN pool to exercise refresh and eviction.
    for (int c = 0; c < 10000; c++) begin
      flush        = ($urandom_range(0, 31) == 0);
      tlb_wvalid   = ($urandom_range(0, 2) == 0);
      lookup_valid = $urandom_range(0, 1);
      tlb_araddr   = 20'($urandom_range(0, 13));
      tlb_awaddr   = 20'($urandom_range(0, 13));
      tlb_wdata    = 20'($urandom);
      cyc();
    end
    flush = 0; lookup_valid = 0;

    // Reset during a fill: nothing installed, counters cleared.
    tlb_awaddr = 20'h4242; tlb_wdata = 20'h1; tlb_wvalid = 1; reset = 1;
    cyc();
    reset = 0; tlb_wvalid = 0;
    look("reset_fill", 20'h4242, 0, 20'h0);
    chk("reset_hit_cnt2", hit_cnt, 32'd0);
    chk("reset_miss_cnt2", miss_cnt, 32'd0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
